// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// FSM states, owner IDs and counter widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int TMO_W    = 4;
  localparam int STREAK_W = 3;

  function automatic owner_e busy_owner(
    input arb_state_e s
  );
    return (s == DM_BUSY) ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF (fetch) and MEM (load/store).
// Optional anti-starvation guard for IF: define STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_ack,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            stall_if,
  output logic            stall_dm,
  output logic            bus_err
);

  localparam int BW = DW/8;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT-1);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]     mem_be_q, mem_be_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     dm_rdata_q, dm_rdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              bus_err_q, bus_err_d;
  logic              starve;
  logic              tmo_hit;

  assign tmo_hit = (tmo_q == TMO_LAST);

`ifdef STARVE_GUARD_EN
  logic [STREAK_W-1:0] streak_q, streak_d;

  assign starve = if_req &&
    (streak_q == STREAK_W'(MAX_DM_STREAK));

  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE && state_d == IF_BUSY)
      streak_d = '0;
    else if (state_q == IDLE && state_d == DM_BUSY && if_req)
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) streak_q <= '0;
    else        streak_q <= streak_d;
  end
`else
  logic unused_streak_cap;
  assign unused_streak_cap = (MAX_DM_STREAK != 0);
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    tmo_d       = tmo_q;
    bus_err_d   = bus_err_q;
    unique case (state_q)
      IDLE: begin
        // MEM is the older instruction, so it wins ties
        if (dm_req && !starve) begin
          state_d     = DM_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
          tmo_d       = '0;
        end else if (if_req) begin
          state_d     = IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          tmo_d       = '0;
        end
      end
      IF_BUSY, DM_BUSY: begin
        tmo_d = tmo_q + 1'b1;
        if (mem_ready || tmo_hit) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (!mem_ready) bus_err_d = 1'b1;
          if (busy_owner(state_q) == OWN_DM) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      tmo_q       <= tmo_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_dm  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter.
// Honors STARVE_GUARD_EN for the starvation scenario.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW/8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [BW-1:0] dm_be = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          stall_if;
  logic          stall_dm;
  logic          bus_err;

  int errs = 0;
  int checks = 0;

  // expected view of the sticky/held registers
  logic [DW-1:0] exp_if_rd = '0;
  logic [DW-1:0] exp_dm_rd = '0;
  logic          exp_berr = 1'b0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        {63'd0, |{mem_req, mem_we, if_ack, dm_ack, bus_err}},
        64'd0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_be"}, mem_be, 0);
    chk({tag, "_ifrd"}, if_rdata, 0);
    chk({tag, "_dmrd"}, dm_rdata, 0);
  endtask

  task automatic idle_step();
    step();
    chk("idle_acks", {if_ack, dm_ack}, 0);
    chk("idle_req", mem_req, 0);
  endtask

  // Acts as requester bookkeeping and as the memory for one transaction.
  // lat: edges from now until mem_req must be seen high.
  task automatic serve(input bit dm, input int lat,
                       input int waits, input bit tmo,
                       input bit keep,
                       input logic [DW-1:0] rd);
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    logic [DW-1:0] rdv;
    a  = dm ? dm_addr : if_addr;
    we = dm ? dm_we : 1'b0;
    wd = dm ? dm_wdata : '0;
    be = dm ? dm_be : '0;
    for (int i = 1; i < lat; i++) begin
      step();
      chk("pre_req", mem_req, 0);
      chk("stall_if_pre", stall_if, if_req);
    end
    step();
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, a);
    chk("mem_we", mem_we, we);
    chk("mem_wdata", mem_wdata, wd);
    chk("mem_be", mem_be, be);
    chk("stall_if_busy", stall_if, if_req);
    if (tmo) begin
      for (int i = 1; i < 15; i++) begin
        step();
        chk("tmo_noack", {if_ack, dm_ack}, 0);
        chk("tmo_hold", mem_addr, a);
      end
      step();
      exp_berr = 1'b1;
      rdv = '0;
    end else begin
      for (int i = 0; i < waits; i++) begin
        step();
        chk("wait_noack", {if_ack, dm_ack}, 0);
        chk("wait_addr", mem_addr, a);
        chk("wait_wdata", mem_wdata, wd);
        chk("wait_req", mem_req, 1);
      end
      mem_ready = 1'b1;
      mem_rdata = rd;
      step();
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      rdv = rd;
    end
    if (dm) exp_dm_rd = rdv;
    else    exp_if_rd = rdv;
    chk("if_ack", if_ack, !dm);
    chk("dm_ack", dm_ack, dm);
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("dm_rdata", dm_rdata, exp_dm_rd);
    chk("req_drop", mem_req, 0);
    chk("bus_err", bus_err, exp_berr);
    chk("stall_own", dm ? stall_dm : stall_if, 0);
    if (!keep) begin
      if (dm) dm_req = 1'b0;
      else    if_req = 1'b0;
    end
  endtask

  initial begin
    int mode;
    int w;

    // reset state
    step();
    step();
    chk_zero("reset");
    chk("reset_stall", {stall_if, stall_dm}, 0);
    reset = 1'b1;
    idle_step();

    // lone fetch
    if_addr = 32'h40;
    if_req  = 1'b1;
    serve(0, 1, 0, 0, 0, 32'h00A00093);
    idle_step();

    // contention: store first, fetch after
    if_addr  = 32'h44;
    dm_we    = 1'b1;
    dm_addr  = 32'h100;
    dm_wdata = 32'hDEADBEEF;
    dm_be    = 4'hF;
    if_req   = 1'b1;
    dm_req   = 1'b1;
    serve(1, 1, 0, 0, 0, 32'h1234_5678);
    serve(0, 2, 0, 0, 0, 32'h0000_0013);
    idle_step();

    // wait states
    dm_we   = 1'b0;
    dm_addr = 32'h200;
    dm_be   = 4'h3;
    dm_req  = 1'b1;
    serve(1, 1, 5, 0, 0, 32'hCAFE_F00D);
    idle_step();

    // timeout, then normal service with sticky error
    dm_addr = 32'h300;
    dm_req  = 1'b1;
    serve(1, 1, 0, 1, 0, '0);
    idle_step();
    if_addr = 32'h48;
    if_req  = 1'b1;
    serve(0, 1, 1, 0, 0, 32'h0010_0073);
    idle_step();

    // reset during DM_BUSY
    dm_we    = 1'b1;
    dm_addr  = 32'h400;
    dm_wdata = 32'h5555_AAAA;
    dm_req   = 1'b1;
    step();
    chk("rst_busy_req", mem_req, 1);
    step();
    reset = 1'b0;
    #1;
    chk("rst_async_req", mem_req, 0);
    chk("rst_no_ack", dm_ack, 0);
    dm_req = 1'b0;
    step();
    step();
    chk_zero("rst_hold");
    reset = 1'b1;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    exp_berr  = 1'b0;
    idle_step();
    chk_zero("rst_after");
    if_addr = 32'h80;
    if_req  = 1'b1;
    serve(0, 1, 0, 0, 0, 32'hFEED_0001);
    idle_step();

    // randomized rounds; MEM is served before IF whenever both ask
    for (int r = 0; r < 24; r++) begin
      mode     = $urandom_range(0, 2);
      w        = $urandom_range(0, 4);
      if_addr  = $urandom;
      dm_we    = 1'($urandom_range(0, 1));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      dm_be    = BW'($urandom_range(1, 15));
      if (mode != 1) if_req = 1'b1;
      if (mode != 0) dm_req = 1'b1;
      if (mode == 0) begin
        serve(0, 1, w, 0, 0, $urandom);
      end else begin
        serve(1, 1, w, 0, 0, $urandom);
        if (mode == 2)
          serve(0, 2, $urandom_range(0, 4), 0, 0, $urandom);
      end
      idle_step();
    end

    // back-to-back MEM traffic with IF waiting
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    exp_berr  = 1'b0;
    idle_step();
    if_addr = 32'hC0;
    dm_we   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dm_addr = $urandom;
      serve(1, (k == 0) ? 1 : 2, 0, 0, 1, $urandom);
    end
`ifdef STARVE_GUARD_EN
    serve(0, 2, 0, 0, 0, 32'h0000_006F);
    dm_req = 1'b0;
`else
    for (int k = 0; k < 3; k++) begin
      dm_addr = $urandom;
      serve(1, 2, 0, 0, 1, $urandom);
    end
    dm_req = 1'b0;
    if_req = 1'b0;
`endif
    idle_step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
